dm_arbiter: RTL and testbench

Two-port arbiter in front of the single-port data memory. It shares the memory between the CPU load/store stage (port c) and the debug/loader port (port d), which handles program load and memory inspection. Per cycle it selects one requester and drives the memory's enable, op, write-enable, address and write-data. It registers the selected read data back to that requester with a one-cycle valid pulse. Port c has fixed priority. A starvation counter guarantees port d one grant after at most STARVE_LIMIT consecutive denied cycles.

---
 rtl/dm_arbiter_pkg.sv | 42 ++++
 rtl/dm_arbiter_if.sv | 30 +++
 rtl/dm_arb_port_rsp.sv | 34 +++
 rtl/dm_arbiter.sv | 100 ++++++++++
 tb/tb_dm_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: access-size encodings,
// starvation counter width and the per-access request bundle.
package dm_arbiter_pkg;

    localparam int DM_OP_BIT      = 3;
    localparam int DM_ARB_CNT_BIT = 4;

    typedef logic [DM_OP_BIT-1:0] dm_op_t;

    localparam dm_op_t DM_OP_WD = 3'd0;
    localparam dm_op_t DM_OP_UH = 3'd1;
    localparam dm_op_t DM_OP_UB = 3'd2;
    localparam dm_op_t DM_OP_SH = 3'd3;
    localparam dm_op_t DM_OP_SB = 3'd4;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_C    = 2'd1,
        SEL_D    = 2'd2
    } dm_sel_e;

    typedef struct packed {
        logic        we;
        dm_op_t      op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_acc_t;

    localparam dm_acc_t DM_ACC_IDLE = '{we: 1'b0, op: DM_OP_WD, addr: 32'h0, wdata: 32'h0};

    function automatic dm_acc_t dm_pick(input dm_sel_e sel, input dm_acc_t c_acc,
                                        input dm_acc_t d_acc);
        dm_acc_t res;
        case (sel)
            SEL_C:   res = c_acc;
            SEL_D:   res = d_acc;
            default: res = DM_ACC_IDLE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side port bundle (CPU or debug) and the memory-side bundle of the arbiter.
interface dm_port_if;
    import dm_arbiter_pkg::*;

    logic        req;
    logic        we;
    dm_op_t      op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, op, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, op, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dm_mem_if;
    import dm_arbiter_pkg::*;

    logic        en;
    logic        w_en;
    dm_op_t      op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, w_en, op, addr, wdata, input rdata);
    modport slave  (input en, w_en, op, addr, wdata, output rdata);
endinterface

// File: rtl/dm_arb_port_rsp.sv
// Per-port read response: captures memory read data on a granted read and
// raises rvalid for exactly the following cycle. Data holds until the next read.
module dm_arb_port_rsp (
    input  logic        clk,
    input  logic        rst,
    input  logic        gnt_i,
    input  logic        we_i,
    input  logic [31:0] rdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        capture;

    assign capture = gnt_i && !we_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= capture;
            if (capture) begin
                rdata_q <= rdata_i;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU port c has fixed priority,
// debug port d is forced through after STARVE_LIMIT consecutive denied cycles.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic       clk,
    input logic       rst,
    dm_port_if.slave  c,
    dm_port_if.slave  d,
    dm_mem_if.master  m
);

    localparam logic [DM_ARB_CNT_BIT-1:0] LIMIT = DM_ARB_CNT_BIT'(STARVE_LIMIT);

    logic [DM_ARB_CNT_BIT-1:0] starve_cnt_q;
    logic [DM_ARB_CNT_BIT-1:0] starve_cnt_d;
    logic                      force_d;
    logic                      c_gnt;
    logic                      d_gnt;
    dm_sel_e                   sel;
    dm_acc_t                   c_acc;
    dm_acc_t                   d_acc;
    dm_acc_t                   win_acc;

    // Grants are gated by rst so nothing reaches the memory while reset is held.
    assign force_d = (starve_cnt_q == LIMIT) && d.req;
    assign c_gnt   = !rst && c.req && !force_d;
    assign d_gnt   = !rst && d.req && (!c.req || force_d);

    assign c.gnt = c_gnt;
    assign d.gnt = d_gnt;

    assign c_acc = '{we: c.we, op: c.op, addr: c.addr, wdata: c.wdata};
    assign d_acc = '{we: d.we, op: d.op, addr: d.addr, wdata: d.wdata};

    always_comb begin
        sel = SEL_NONE;
        if (c_gnt) begin
            sel = SEL_C;
        end else if (d_gnt) begin
            sel = SEL_D;
        end
    end

    assign win_acc = dm_pick(sel, c_acc, d_acc);

    assign m.en    = (sel != SEL_NONE);
    assign m.w_en  = win_acc.we;
    assign m.op    = win_acc.op;
    assign m.addr  = win_acc.addr;
    assign m.wdata = win_acc.wdata;

    // A forced grant is itself a d grant, so the counter clears right after it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (d_gnt || !d.req) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    logic        port_gnt    [2];
    logic        port_we     [2];
    logic        port_rvalid [2];
    logic [31:0] port_rdata  [2];

    assign port_gnt[0] = c_gnt;
    assign port_gnt[1] = d_gnt;
    assign port_we[0]  = c.we;
    assign port_we[1]  = d.we;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        dm_arb_port_rsp u_rsp (
            .clk      (clk),
            .rst      (rst),
            .gnt_i    (port_gnt[gi]),
            .we_i     (port_we[gi]),
            .rdata_i  (m.rdata),
            .rvalid_o (port_rvalid[gi]),
            .rdata_o  (port_rdata[gi])
        );
    end

    assign c.rvalid = port_rvalid[0];
    assign c.rdata  = port_rdata[0];
    assign d.rvalid = port_rvalid[1];
    assign d.rdata  = port_rdata[1];

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: stimulus checks grants and queues expected read
// data; a negedge monitor pops and compares on every rvalid pulse.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    logic clk;
    logic rst;

    dm_port_if c_if ();
    dm_port_if d_if ();
    dm_mem_if  m_if ();

    dm_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .c   (c_if),
        .d   (d_if),
        .m   (m_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- byte-addressed little-endian memory model ----------------
    logic [7:0]  mem_b [0:255];
    logic [7:0]  rd_base;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_base = {m_if.addr[7:2], 2'b00};
        rd_word = {mem_b[8'(rd_base + 8'd3)], mem_b[8'(rd_base + 8'd2)],
                   mem_b[8'(rd_base + 8'd1)], mem_b[rd_base]};
        rd_byte = rd_word[{m_if.addr[1:0], 3'b000} +: 8];
        rd_half = m_if.addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (m_if.op)
            DM_OP_UH: m_if.rdata = {16'h0, rd_half};
            DM_OP_SH: m_if.rdata = {{16{rd_half[15]}}, rd_half};
            DM_OP_UB: m_if.rdata = {24'h0, rd_byte};
            DM_OP_SB: m_if.rdata = {{24{rd_byte[7]}}, rd_byte};
            default:  m_if.rdata = rd_word;
        endcase
    end

    always @(posedge clk) begin
        if (m_if.en && m_if.w_en) begin
            case (m_if.op)
                DM_OP_UH, DM_OP_SH: begin
                    mem_b[{m_if.addr[7:1], 1'b0}] <= m_if.wdata[7:0];
                    mem_b[{m_if.addr[7:1], 1'b1}] <= m_if.wdata[15:8];
                end
                DM_OP_UB, DM_OP_SB: mem_b[m_if.addr[7:0]] <= m_if.wdata[7:0];
                default: begin
                    mem_b[{m_if.addr[7:2], 2'b00}] <= m_if.wdata[7:0];
                    mem_b[{m_if.addr[7:2], 2'b01}] <= m_if.wdata[15:8];
                    mem_b[{m_if.addr[7:2], 2'b10}] <= m_if.wdata[23:16];
                    mem_b[{m_if.addr[7:2], 2'b11}] <= m_if.wdata[31:24];
                end
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int          n_tests;
    int          n_fail;
    logic [31:0] c_exp_q [$];
    logic [31:0] d_exp_q [$];
    logic [31:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (c_if.rvalid) begin
            if (c_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL c_rsp unexpected rvalid actual=%h required=none", c_if.rdata);
            end else begin
                mon_exp = c_exp_q.pop_front();
                $display("[TB] c response rdata=%h", c_if.rdata);
                chk("c_rsp", c_if.rdata, mon_exp);
            end
        end
        if (d_if.rvalid) begin
            if (d_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL d_rsp unexpected rvalid actual=%h required=none", d_if.rdata);
            end else begin
                mon_exp = d_exp_q.pop_front();
                $display("[TB] d response rdata=%h", d_if.rdata);
                chk("d_rsp", d_if.rdata, mon_exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_c(input logic req, input logic we, input dm_op_t op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        c_if.req = req; c_if.we = we; c_if.op = op; c_if.addr = addr; c_if.wdata = wdata;
    endtask

    task automatic set_d(input logic req, input logic we, input dm_op_t op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        d_if.req = req; d_if.we = we; d_if.op = op; d_if.addr = addr; d_if.wdata = wdata;
    endtask

    // Called just after a negedge with inputs applied; checks grants, queues the
    // expected read data, and advances across one rising edge to the next negedge.
    task automatic step(input logic ec, input logic ed, input logic [31:0] exp_c,
                        input logic [31:0] exp_d, input string tag);
        #1;
        $display("[TB] %s c_gnt=%0b d_gnt=%0b", tag, c_if.gnt, d_if.gnt);
        chk({tag, " c_gnt"}, 32'(c_if.gnt), 32'(ec));
        chk({tag, " d_gnt"}, 32'(d_if.gnt), 32'(ed));
        if (ec && !c_if.we) c_exp_q.push_back(exp_c);
        if (ed && !d_if.we) d_exp_q.push_back(exp_d);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        set_c(1'b1, 1'b0, DM_OP_WD, 32'h0, 32'h0);
        set_d(1'b1, 1'b0, DM_OP_WD, 32'h4, 32'h0);

        // Reset state with both requests asserted.
        #2;
        chk("rst c_gnt", 32'(c_if.gnt), 32'h0);
        chk("rst d_gnt", 32'(d_if.gnt), 32'h0);
        chk("rst m_en", 32'(m_if.en), 32'h0);
        chk("rst c_rvalid", 32'(c_if.rvalid), 32'h0);
        chk("rst d_rdata", d_if.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_c(1'b0, 1'b0, DM_OP_WD, 32'h0, 32'h0);

        // Program load through the debug port.
        set_d(1'b1, 1'b1, DM_OP_WD, 32'h000, 32'h8899AABB);
        step(1'b0, 1'b1, 32'h0, 32'h0, "load 0x000");
        set_d(1'b1, 1'b1, DM_OP_WD, 32'h020, 32'h11223344);
        step(1'b0, 1'b1, 32'h0, 32'h0, "load 0x020");
        set_d(1'b1, 1'b1, DM_OP_WD, 32'h024, 32'h55667788);
        step(1'b0, 1'b1, 32'h0, 32'h0, "load 0x024");
        set_d(1'b0, 1'b0, DM_OP_WD, 32'h0, 32'h0);

        // Single CPU reads of sub-word sizes.
        set_c(1'b1, 1'b0, DM_OP_SB, 32'h001, 32'h0);
        step(1'b1, 1'b0, 32'hFFFFFFAA, 32'h0, "c rd SB 0x001");
        set_c(1'b1, 1'b0, DM_OP_UB, 32'h002, 32'h0);
        step(1'b1, 1'b0, 32'h00000099, 32'h0, "c rd UB 0x002");
        set_c(1'b1, 1'b0, DM_OP_SH, 32'h002, 32'h0);
        step(1'b1, 1'b0, 32'hFFFF8899, 32'h0, "c rd SH 0x002");
        set_c(1'b0, 1'b0, DM_OP_WD, 32'h0, 32'h0);

        // Debug write then CPU read.
        set_d(1'b1, 1'b1, DM_OP_WD, 32'h010, 32'hDEADBEEF);
        #1;
        chk("d wr m_w_en", 32'(m_if.w_en), 32'h1);
        chk("d wr m_addr", m_if.addr, 32'h10);
        chk("d wr m_wdata", m_if.wdata, 32'hDEADBEEF);
        step(1'b0, 1'b1, 32'h0, 32'h0, "d wr WD 0x010");
        set_d(1'b0, 1'b0, DM_OP_WD, 32'h0, 32'h0);
        set_c(1'b1, 1'b0, DM_OP_UH, 32'h012, 32'h0);
        step(1'b1, 1'b0, 32'h0000DEAD, 32'h0, "c rd UH 0x012");

        // Contention: c,c,c,c,d repeating.
        set_c(1'b1, 1'b0, DM_OP_WD, 32'h020, 32'h0);
        set_d(1'b1, 1'b0, DM_OP_WD, 32'h024, 32'h0);
        for (int i = 1; i <= 12; i++) begin
            step((i % 5) != 0, (i % 5) == 0, 32'h11223344, 32'h55667788, "contend");
        end

        // Starvation abort: one idle-d cycle to settle, then 3 high, 1 low, then high.
        set_d(1'b0, 1'b0, DM_OP_WD, 32'h024, 32'h0);
        step(1'b1, 1'b0, 32'h11223344, 32'h0, "settle");
        for (int i = 0; i < 9; i++) begin
            d_if.req = (i != 3);
            step(i != 8, i == 8, 32'h11223344, 32'h55667788, "abort");
        end

        // Reset during a granted debug read.
        set_c(1'b0, 1'b0, DM_OP_WD, 32'h0, 32'h0);
        set_d(1'b1, 1'b0, DM_OP_WD, 32'h024, 32'h0);
        #1;
        chk("pre-rst d_gnt", 32'(d_if.gnt), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid-rst d_rvalid", 32'(d_if.rvalid), 32'h0);
        chk("mid-rst d_rdata", d_if.rdata, 32'h0);
        chk("mid-rst c_rdata", c_if.rdata, 32'h0);
        chk("mid-rst m_en", 32'(m_if.en), 32'h0);
        chk("mid-rst d_gnt", 32'(d_if.gnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 32'h0, 32'h55667788, "post-rst d rd");
        set_d(1'b0, 1'b0, DM_OP_WD, 32'h0, 32'h0);
        set_c(1'b1, 1'b0, DM_OP_WD, 32'h020, 32'h0);
        step(1'b1, 1'b0, 32'h11223344, 32'h0, "post-rst c rd");

        // Idle: memory port quiet and contents untouched.
        set_c(1'b0, 1'b0, DM_OP_WD, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle m_en", 32'(m_if.en), 32'h0);
            chk("idle m_w_en", 32'(m_if.w_en), 32'h0);
            chk("idle m_addr", m_if.addr, 32'h0);
            chk("idle m_op", 32'(m_if.op), 32'(DM_OP_WD));
            chk("idle m_wdata", m_if.wdata, 32'h0);
            step(1'b0, 1'b0, 32'h0, 32'h0, "idle");
        end
        chk("idle mem 0x010", {mem_b[8'h13], mem_b[8'h12], mem_b[8'h11], mem_b[8'h10]},
            32'hDEADBEEF);
        chk("idle mem 0x000", {mem_b[8'h03], mem_b[8'h02], mem_b[8'h01], mem_b[8'h00]},
            32'h8899AABB);

        @(negedge clk);
        #2;
        chk("c queue drained", 32'(c_exp_q.size()), 32'h0);
        chk("d queue drained", 32'(d_exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
